// File: rtl/link_power_sequencer_pkg.sv
// Shared types for the link power sequencer: pair state encoding and counter sizing.
// Retry behaviour of faulted pairs is selected with the LINK_POWER_RETRY_EN macro.
package link_power_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_DETECT    = 3'd1,
        ST_WAIT_RAMP = 3'd2,
        ST_RAMP      = 3'd3,
        ST_POWERED   = 3'd4,
        ST_FAULT     = 3'd5,
        ST_COOLDOWN  = 3'd6
    } pair_state_e;

    // One spare bit above the largest phase length so counters can saturate without wrapping.
    function automatic int cnt_width(input int detect_cycles, input int ramp_cycles,
                                     input int blank_cycles, input int cooldown_cycles);
        int largest;
        largest = detect_cycles;
        if (ramp_cycles > largest) largest = ramp_cycles;
        if (blank_cycles > largest) largest = blank_cycles;
        if (cooldown_cycles > largest) largest = cooldown_cycles;
        return $clog2(largest) + 1;
    endfunction

endpackage

// File: rtl/link_power_pair_fsm.sv
// Per-pair power flow: detect qualification, arbitrated ramp, powered, fault handling.
// With LINK_POWER_RETRY_EN defined a fault cools down and re-qualifies; otherwise it latches.
module link_power_pair_fsm
    import link_power_pkg::*;
#(
    parameter int DETECT_CYCLES   = 8,
    parameter int RAMP_CYCLES     = 16,
    parameter int OC_BLANK_CYCLES = 4,
    parameter int COOLDOWN_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       detect,
    input  logic       over_current,
    input  logic       grant,
    output logic       req,
    output logic       drive,
    output logic       fault,
    output logic       ramping,
    output logic       powered,
    output logic [2:0] state_code
);

    localparam int CW = cnt_width(DETECT_CYCLES, RAMP_CYCLES, OC_BLANK_CYCLES, COOLDOWN_CYCLES);
    localparam logic [CW-1:0] DET_LAST  = CW'(DETECT_CYCLES - 1);
    localparam logic [CW-1:0] RAMP_LAST = CW'(RAMP_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(OC_BLANK_CYCLES);
    localparam logic [CW-1:0] CNT_MAX   = '1;
`ifdef LINK_POWER_RETRY_EN
    localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_CYCLES - 1);
`endif

    pair_state_e   state_q;
    pair_state_e   state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Dropping the enable overrides every other transition, including a same-cycle overcurrent.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_DETECT;
                    cnt_d   = '0;
                end
                ST_DETECT: begin
                    if (!detect) begin
                        cnt_d = '0;
                    end else if (cnt_q == DET_LAST) begin
                        state_d = ST_WAIT_RAMP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_WAIT_RAMP: begin
                    if (grant) begin
                        state_d = ST_RAMP;
                        cnt_d   = '0;
                    end
                end
                ST_RAMP: begin
                    if (over_current && (cnt_q >= BLANK_END)) begin
                        state_d = ST_FAULT;
                        cnt_d   = '0;
                    end else if (cnt_q == RAMP_LAST) begin
                        state_d = ST_POWERED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_POWERED: begin
                    if (over_current) begin
                        state_d = ST_FAULT;
                        cnt_d   = '0;
                    end
                end
                ST_FAULT: begin
`ifdef LINK_POWER_RETRY_EN
                    state_d = ST_COOLDOWN;
                    cnt_d   = '0;
`else
                    state_d = ST_FAULT;
`endif
                end
                ST_COOLDOWN: begin
`ifdef LINK_POWER_RETRY_EN
                    if (cnt_q == COOL_LAST) begin
                        state_d = ST_DETECT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
`else
                    state_d = ST_OFF;
                    cnt_d   = '0;
`endif
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // A pair that is being switched off never competes for the ramp slot.
    assign req        = (state_q == ST_WAIT_RAMP) && enable;
    assign drive      = (state_q == ST_RAMP) || (state_q == ST_POWERED);
    assign fault      = (state_q == ST_FAULT);
    assign ramping    = (state_q == ST_RAMP);
    assign powered    = (state_q == ST_POWERED);
    assign state_code = state_q;

endmodule

// File: rtl/link_power_sequencer.sv
// Link power controller: one flow per pair plus a round-robin ramp-slot arbiter.
// Faulted-pair retry is enabled by defining LINK_POWER_RETRY_EN.
module link_power_sequencer
    import link_power_pkg::*;
#(
    parameter int PAIR_COUNT      = 2,
    parameter int DETECT_CYCLES   = 8,
    parameter int RAMP_CYCLES     = 16,
    parameter int OC_BLANK_CYCLES = 4,
    parameter int COOLDOWN_CYCLES = 32
) (
    input  logic                    Clock100MhzP,
    input  logic                    ResetN,
    input  logic [PAIR_COUNT-1:0]   PairEnable,
    input  logic [PAIR_COUNT-1:0]   PairDetect,
    input  logic [PAIR_COUNT-1:0]   PairOverCurrent,
    input  logic [PAIR_COUNT-1:0]   RedirectMode,
    output logic [PAIR_COUNT-1:0]   PairDrive,
    output logic [PAIR_COUNT-1:0]   PairRedirect,
    output logic [PAIR_COUNT-1:0]   PairFault,
    output logic [3*PAIR_COUNT-1:0] PairState,
    output logic                    RampBusy
);

    localparam int PW = (PAIR_COUNT > 1) ? $clog2(PAIR_COUNT) : 1;

    logic [PAIR_COUNT-1:0] req;
    logic [PAIR_COUNT-1:0] grant;
    logic [PAIR_COUNT-1:0] drive;
    logic [PAIR_COUNT-1:0] fault;
    logic [PAIR_COUNT-1:0] ramping;
    logic [PAIR_COUNT-1:0] powered;
    logic [PW-1:0]         ptr_q;
    logic [PW-1:0]         ptr_d;
    logic                  granted_q;
    logic                  grant_any;
    logic                  any_ramp;

    for (genvar g = 0; g < PAIR_COUNT; g++) begin : g_pair
        link_power_pair_fsm #(
            .DETECT_CYCLES  (DETECT_CYCLES),
            .RAMP_CYCLES    (RAMP_CYCLES),
            .OC_BLANK_CYCLES(OC_BLANK_CYCLES),
            .COOLDOWN_CYCLES(COOLDOWN_CYCLES)
        ) u_pair (
            .clk         (Clock100MhzP),
            .rst_n       (ResetN),
            .enable      (PairEnable[g]),
            .detect      (PairDetect[g]),
            .over_current(PairOverCurrent[g]),
            .grant       (grant[g]),
            .req         (req[g]),
            .drive       (drive[g]),
            .fault       (fault[g]),
            .ramping     (ramping[g]),
            .powered     (powered[g]),
            .state_code  (PairState[3*g +: 3])
        );
    end

    assign any_ramp = |ramping;

    // The slot stays closed while any pair ramps and for one cycle after each grant.
    always_comb begin
        int idx;
        grant     = '0;
        grant_any = 1'b0;
        ptr_d     = ptr_q;
        idx       = 0;
        if (!any_ramp && !granted_q) begin
            for (int k = 0; k < PAIR_COUNT; k++) begin
                idx = (int'(ptr_q) + k) % PAIR_COUNT;
                if (!grant_any && req[idx]) begin
                    grant[idx] = 1'b1;
                    grant_any  = 1'b1;
                    ptr_d      = PW'((idx + 1) % PAIR_COUNT);
                end
            end
        end
    end

    always_ff @(posedge Clock100MhzP or negedge ResetN) begin
        if (!ResetN) begin
            ptr_q     <= '0;
            granted_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            granted_q <= grant_any;
        end
    end

    assign PairDrive    = drive;
    assign PairFault    = fault;
    assign PairRedirect = powered & RedirectMode;
    assign RampBusy     = any_ramp;

endmodule

// File: tb/tb_link_power_sequencer.sv
// Self-checking bench for link_power_sequencer with four pairs against a behavioural model.
// The model follows LINK_POWER_RETRY_EN the same way the design does.
module tb_link_power_sequencer;

    localparam int N  = 4;
    localparam int DC = 8;
    localparam int RC = 16;
    localparam int OB = 4;
    localparam int CC = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   en, det, oc, rmode;
    logic [N-1:0]   drive, redir, fault;
    logic [3*N-1:0] pstate;
    logic           busy;

    int checks = 0;
    int errors = 0;

    // Reference model: phase code per pair, cycles spent in current phase, arbiter memory.
    int m_st[N];
    int m_age[N];
    int m_ptr;
    bit m_granted_last;

    link_power_sequencer #(
        .PAIR_COUNT(N), .DETECT_CYCLES(DC), .RAMP_CYCLES(RC),
        .OC_BLANK_CYCLES(OB), .COOLDOWN_CYCLES(CC)
    ) dut (
        .Clock100MhzP(clk), .ResetN(rst_n), .PairEnable(en), .PairDetect(det),
        .PairOverCurrent(oc), .RedirectMode(rmode), .PairDrive(drive),
        .PairRedirect(redir), .PairFault(fault), .PairState(pstate), .RampBusy(busy)
    );

    always #5 clk = ~clk;

    function automatic void modelReset();
        for (int i = 0; i < N; i++) begin
            m_st[i]  = 0;
            m_age[i] = 0;
        end
        m_ptr          = 0;
        m_granted_last = 0;
    endfunction

    function automatic void modelStep();
        int  g;
        bit  slot_busy;
        int  ns[N];
        int  na[N];
        g         = -1;
        slot_busy = 0;
        for (int i = 0; i < N; i++) if (m_st[i] == 3) slot_busy = 1;
        if (!slot_busy && !m_granted_last) begin
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_ptr + k) % N;
                if (g < 0 && m_st[p] == 2 && en[p]) g = p;
            end
        end
        for (int i = 0; i < N; i++) begin
            ns[i] = m_st[i];
            na[i] = m_age[i] + 1;
            if (!en[i]) begin
                ns[i] = 0; na[i] = 0;
            end else begin
                case (m_st[i])
                    0: begin ns[i] = 1; na[i] = 0; end
                    1: begin
                        if (!det[i]) na[i] = 0;
                        else if (m_age[i] + 1 == DC) begin ns[i] = 2; na[i] = 0; end
                    end
                    2: begin na[i] = 0; if (i == g) ns[i] = 3; end
                    3: begin
                        if (oc[i] && m_age[i] >= OB) begin ns[i] = 5; na[i] = 0; end
                        else if (m_age[i] + 1 == RC) begin ns[i] = 4; na[i] = 0; end
                    end
                    4: begin na[i] = 0; if (oc[i]) ns[i] = 5; end
`ifdef LINK_POWER_RETRY_EN
                    5: begin ns[i] = 6; na[i] = 0; end
                    6: if (m_age[i] + 1 == CC) begin ns[i] = 1; na[i] = 0; end
`else
                    5: na[i] = 0;
`endif
                    default: begin ns[i] = 0; na[i] = 0; end
                endcase
            end
        end
        for (int i = 0; i < N; i++) begin
            m_st[i]  = ns[i];
            m_age[i] = na[i];
        end
        m_granted_last = (g >= 0);
        if (g >= 0) m_ptr = (g + 1) % N;
    endfunction

    task automatic checkEq(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [3*N-1:0] e_state;
        logic [N-1:0]   e_drive, e_redir, e_fault;
        logic           e_busy;
        e_busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            e_state[3*i +: 3] = 3'(m_st[i]);
            e_drive[i] = (m_st[i] == 3) || (m_st[i] == 4);
            e_redir[i] = (m_st[i] == 4) && rmode[i];
            e_fault[i] = (m_st[i] == 5);
            if (m_st[i] == 3) e_busy = 1'b1;
        end
        checks++;
        assert (pstate === e_state) else begin
            errors++; $error("[TB] FAIL %s PairState observed=%h expected=%h", tag, pstate, e_state);
        end
        checks++;
        assert (drive === e_drive) else begin
            errors++; $error("[TB] FAIL %s PairDrive observed=%b expected=%b", tag, drive, e_drive);
        end
        checks++;
        assert (redir === e_redir) else begin
            errors++; $error("[TB] FAIL %s PairRedirect observed=%b expected=%b", tag, redir, e_redir);
        end
        checks++;
        assert (fault === e_fault) else begin
            errors++; $error("[TB] FAIL %s PairFault observed=%b expected=%b", tag, fault, e_fault);
        end
        checks++;
        assert (busy === e_busy) else begin
            errors++; $error("[TB] FAIL %s RampBusy observed=%b expected=%b", tag, busy, e_busy);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] e, input logic [N-1:0] d,
                                 input logic [N-1:0] o, input logic [N-1:0] r);
        en = e; det = d; oc = o; rmode = r;
    endtask

    task automatic tick(input string tag);
        modelStep();
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        modelReset();
        #3;
        checkOutput("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int starts[$];
        int start_cyc[$];
        int nramp;
        logic [N-1:0] ev;

        applyStimulus('0, '0, '0, '0);
        doReset();
        checkEq("reset_state", int'(pstate), 0);
        checkEq("reset_drive", int'(drive), 0);

        // Single-pair bring-up with redirect
        applyStimulus(4'b0001, 4'b1111, 4'b0000, 4'b0001);
        for (int n = 1; n <= 30; n++) begin
            tick("bringup");
            if (n == 1)  checkEq("bringup_detect", int'(pstate[2:0]), 1);
            if (n == 8)  checkEq("bringup_still_detect", int'(pstate[2:0]), 1);
            if (n == 9)  checkEq("bringup_wait", int'(pstate[2:0]), 2);
            if (n == 10) checkEq("bringup_ramp_drive", int'(drive[0]), 1);
            if (n == 25) checkEq("bringup_ramp_last", int'(pstate[2:0]), 3);
            if (n == 26) checkEq("bringup_powered", int'(pstate[2:0]), 4);
            if (n == 26) checkEq("bringup_redirect", int'(redir[0]), 1);
        end

        // Detect glitch on pair 1
        doReset();
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 4'b0000);
        tick("glitch");
        for (int n = 0; n < 5; n++) tick("glitch");
        applyStimulus(4'b0010, 4'b0000, 4'b0000, 4'b0000);
        tick("glitch_low");
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 4'b0000);
        for (int n = 0; n < 7; n++) tick("glitch");
        checkEq("glitch_not_yet", int'(pstate[5:3]), 1);
        tick("glitch");
        checkEq("glitch_qualified", int'(pstate[5:3]), 2);

        // All pairs qualify together; ramps must be serialised in index order
        doReset();
        applyStimulus(4'b1111, 4'b1111, 4'b0000, 4'b1010);
        for (int n = 1; n <= 100; n++) begin
            logic [3*N-1:0] prev;
            prev = pstate;
            tick("stagger");
            nramp = 0;
            for (int i = 0; i < N; i++) begin
                if (pstate[3*i +: 3] == 3'd3) nramp++;
                if (pstate[3*i +: 3] == 3'd3 && prev[3*i +: 3] != 3'd3) begin
                    starts.push_back(i);
                    start_cyc.push_back(n);
                end
            end
            checkEq("stagger_single_ramp", int'(nramp <= 1), 1);
        end
        checkEq("stagger_count", starts.size(), 4);
        for (int k = 0; k < starts.size(); k++) begin
            checkEq("stagger_order", starts[k], k);
            if (k > 0) checkEq("stagger_gap", int'(start_cyc[k] - start_cyc[k-1] >= RC + 1), 1);
        end

        // Overcurrent blanking: pulse at ramp count 2 ignored, at 5 faults
        doReset();
        applyStimulus(4'b0001, 4'b0001, 4'b0000, 4'b0000);
        for (int n = 0; n < 40; n++) begin
            bit early, late;
            early = (m_st[0] == 3 && m_age[0] == 2);
            late  = (m_st[0] == 3 && m_age[0] == 5);
            oc = {3'b000, early | late};
            tick("blank");
            if (early) checkEq("blank_ignored", int'(pstate[2:0]), 3);
            if (late) begin
                checkEq("blank_fault_state", int'(pstate[2:0]), 5);
                checkEq("blank_fault_flag", int'(fault[0]), 1);
                checkEq("blank_drive_off", int'(drive[0]), 0);
            end
        end

        // Fault policy
        oc = '0;
`ifdef LINK_POWER_RETRY_EN
        for (int n = 0; n < 60; n++) tick("retry");
        checkEq("retry_back_in_flow", int'(fault[0]), 0);
`else
        for (int n = 0; n < 10; n++) tick("latch");
        checkEq("latch_held", int'(pstate[2:0]), 5);
        en = 4'b0000;
        tick("latch_release");
        checkEq("latch_off", int'(pstate[2:0]), 0);
`endif

        // Enable-low beats overcurrent while powered
        doReset();
        applyStimulus(4'b0001, 4'b0001, 4'b0000, 4'b0000);
        for (int n = 0; n < 28; n++) tick("prio_up");
        checkEq("prio_powered", int'(pstate[2:0]), 4);
        applyStimulus(4'b0000, 4'b0001, 4'b0001, 4'b0000);
        tick("prio");
        checkEq("prio_off", int'(pstate[2:0]), 0);
        checkEq("prio_no_fault", int'(fault[0]), 0);

        // Asynchronous reset during ramp
        doReset();
        applyStimulus(4'b0001, 4'b0001, 4'b0000, 4'b0000);
        for (int n = 0; n < 12; n++) tick("areset_up");
        checkEq("areset_ramping", int'(drive[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkEq("areset_drive_drop", int'(drive[0]), 0);
        modelReset();
        checkOutput("areset");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic
        doReset();
        ev = 4'b1111;
        for (int n = 0; n < 3000; n++) begin
            logic [N-1:0] d, o, r;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 49) == 0) ev[i] = ~ev[i];
                d[i] = ($urandom_range(0, 15) != 0);
                o[i] = ($urandom_range(0, 63) == 0);
                r[i] = $urandom_range(0, 1) != 0;
            end
            applyStimulus(ev, d, o, r);
            tick("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/link_power_sequencer.md
Name: link_power_sequencer

Overview:
- Parametrised link-power controller for PAIR_COUNT TIA-568B pair channels. It generalises the fixed two-pair (12/36, 54/78) power-and-redirect path.
- Each pair runs its own flow: detect, then staggered ramp, then powered with optional pair redirect, with fault handling.
- A shared round-robin arbiter lets only one pair ramp at a time, which limits inrush on the supply.
- Sits between the pair sense comparators and the op-amp drive/redirect enables.

Parameters:
- PAIR_COUNT, 2, number of pair channels (>=1).
- DETECT_CYCLES, 8, consecutive PairDetect-high cycles needed to qualify a pair (>=1).
- RAMP_CYCLES, 16, cycles a pair spends in RAMP holding the ramp slot (>=2).
- OC_BLANK_CYCLES, 4, initial RAMP cycles during which PairOverCurrent is ignored (< RAMP_CYCLES).
- COOLDOWN_CYCLES, 32, COOLDOWN duration, used only with retry (>=1).

Ports:
- Clock100MhzP  in  1  system clock, rising edge.
- ResetN  in  1  asynchronous active-low reset.
- PairEnable  in  PAIR_COUNT  per-pair power request, synchronous level.
- PairDetect  in  PAIR_COUNT  valid-signature comparator, synchronous.
- PairOverCurrent  in  PAIR_COUNT  overcurrent comparator, synchronous.
- RedirectMode  in  PAIR_COUNT  when set, a powered pair routes first half to second half (12->36 style).
- PairDrive  out  PAIR_COUNT  op-amp drive enable.
- PairRedirect  out  PAIR_COUNT  redirect op-amp enable.
- PairFault  out  PAIR_COUNT  pair is in FAULT.
- PairState  out  3*PAIR_COUNT  encoded state, pair i at bits [3i+2:3i].
- RampBusy  out  1  some pair holds the ramp slot.

Behaviour:
- State encoding: OFF=0, DETECT=1, WAIT_RAMP=2, RAMP=3, POWERED=4, FAULT=5, COOLDOWN=6. Code 7 is illegal and is forced to OFF on the next edge.
- Reset (ResetN low, async): all states OFF, all counters 0, arbiter pointer 0. All outputs 0; PairState 0.
- Reset mid-operation behaves identically: PairDrive drops asynchronously.
- Outputs are registered and decoded from the state register:
  - PairDrive=1 in RAMP or POWERED.
  - PairRedirect=1 in POWERED and RedirectMode[i] (RedirectMode sampled live).
  - PairFault=1 in FAULT.
  - RampBusy=1 if any pair is in RAMP.
- PairEnable low in any state: pair goes to OFF on the next edge and its counter clears. This has priority over every other transition.
- OFF: PairEnable=1 -> DETECT, counter=0.
- DETECT:
  - PairDetect=1 increments the counter; PairDetect=0 clears it.
  - When PairDetect=1 and counter==DETECT_CYCLES-1 -> WAIT_RAMP.
  - Net effect: DETECT_CYCLES consecutive high samples qualify the pair.
- WAIT_RAMP: raises a ramp request.
  - Arbiter grants at most one request per cycle, and only when no pair is in RAMP and no grant was issued the previous cycle.
  - Priority is round-robin, searching from pointer upward with wrap-around.
  - On grant: pair -> RAMP, counter=0, pointer = granted index +1 mod PAIR_COUNT.
  - Simultaneous requests are served in pointer order.
- RAMP:
  - Counter increments each cycle.
  - PairOverCurrent=1 while counter >= OC_BLANK_CYCLES -> FAULT.
  - Otherwise at counter==RAMP_CYCLES-1 -> POWERED.
  - The slot is released when the pair leaves RAMP; another pair may be granted on the edge after.
- POWERED: PairOverCurrent=1 -> FAULT next edge. PairDetect is ignored.
- FAULT: behaviour depends on the optional feature. PairEnable low always -> OFF.
- Overcurrent and enable-low on the same cycle: OFF wins.
- Counter width is $clog2 of the largest cycle parameter, plus 1. Counters saturate and never wrap.

Optional Feature:
- Macro: LINK_POWER_RETRY_EN.
- Defined:
  - FAULT lasts exactly one cycle, then COOLDOWN.
  - COOLDOWN counts COOLDOWN_CYCLES with PairDrive=0, then DETECT with counter=0. The pair re-qualifies and re-arbitrates.
- Undefined:
  - FAULT latches until PairEnable is deasserted.
  - COOLDOWN is unreachable, and the logic and parameter are unused.

Decomposition:
- Package link_power_pkg holds:
  - state enum (3-bit) and its encodings;
  - a helper function computing counter width.
- Sub-module link_power_pair_fsm: one per pair, generated PAIR_COUNT times. It owns state, counter, request output and grant input.
- Top level holds the round-robin arbiter, RampBusy and output packing.

Test Plan:
- Reset and single-pair bring-up:
  - Stimulus: reset, then PairEnable=2'b01, PairDetect=1 constant.
  - Expected: DETECT for 8 cycles, WAIT_RAMP, RAMP for 16 cycles with PairDrive[0]=1, then POWERED. PairRedirect[0]=1 once POWERED if RedirectMode[0]=1.
- Detect glitch: PairDetect low on the 6th DETECT cycle -> counter clears; WAIT_RAMP is reached only after 8 further consecutive high cycles.
- Staggered ramp:
  - Stimulus: PAIR_COUNT=4, all pairs qualify on the same cycle.
  - Expected: ramps in order 0,1,2,3. RampBusy is never shared by two pairs. Each RAMP starts at least 17 cycles after the previous one.
- Overcurrent blanking:
  - Stimulus: overcurrent pulse at RAMP counter 2, then another at counter 5.
  - Expected: the first is ignored; the second gives FAULT next edge, PairDrive=0, PairFault=1.
- Fault policy:
  - With LINK_POWER_RETRY_EN: FAULT 1 cycle, COOLDOWN 32 cycles, then DETECT.
  - Without it: FAULT held until PairEnable=0, then OFF.
- Priority and async reset:
  - PairEnable low on the same cycle as overcurrent in POWERED -> OFF, with PairFault never set.
  - ResetN low during RAMP -> PairDrive drops immediately.
